dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. It accepts a request from the pipeline's `memRead`/`memWrite`/address/write-data signals and performs the access over a parameterised number of cycles. While the access is in flight it raises `stall` so the pipeline freezes its stage registers. It completes with a one-cycle `done` pulse and registered read data, replacing the zero-latency combinational data memory as the far end of the MEM-stage interface.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder_array.sv | 40 ++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DEF_DEPTH   = 256;
  localparam int unsigned DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the responder (slave).
interface dmem_responder_if;

  logic                       memRead;
  logic                       memWrite;
  logic [dmem_pkg::ADDR_W-1:0] address;
  logic [dmem_pkg::WORD_W-1:0] writeData;
  logic [dmem_pkg::WORD_W-1:0] readData;
  logic                       stall;
  logic                       done;
  logic                       error;

  modport master (
    output memRead, memWrite, address, writeData,
    input  readData, stall, done, error
  );

  modport slave (
    input  memRead, memWrite, address, writeData,
    output readData, stall, done, error
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port synchronous RAM with write enable and a resettable registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [WORD_W-1:0]        wdata_i,
  output logic [WORD_W-1:0]        rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage is never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // clr_i zeroes the read register for loads that skip the array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: stalls the MEM stage for LATENCY cycles, then pulses done.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               store_q;
  logic               mis_q;
  logic               done_q;
  logic               error_q;

  logic               req;
  logic               in_mis;
  logic [IDX_W-1:0]   in_idx;
  logic               unused_addr;

  logic               acc_go;
  logic               acc_store;
  logic               acc_mis;
  logic [IDX_W-1:0]   acc_idx;
  logic [WORD_W-1:0]  acc_wdata;
  logic               arr_we;
  logic               arr_re;
  logic               arr_clr;

  assign req         = bus.memRead | bus.memWrite;
  assign in_mis      = (bus.address[1:0] != 2'b00);
  assign in_idx      = bus.address[IDX_W+1:2];
  assign unused_addr = ^bus.address[ADDR_W-1:IDX_W+2];

  // Array access happens on the edge entering DONE; with LATENCY==1 that is the accept edge.
  always_comb begin
    acc_go    = 1'b0;
    acc_store = store_q;
    acc_mis   = mis_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE && req && LATENCY == 1) begin
      acc_go    = 1'b1;
      acc_store = bus.memWrite;
      acc_mis   = in_mis;
      acc_idx   = in_idx;
      acc_wdata = bus.writeData;
    end else if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
      acc_go    = 1'b1;
    end
    arr_we  = acc_go &  acc_store & ~acc_mis;
    arr_re  = acc_go & ~acc_store & ~acc_mis;
    arr_clr = acc_go & ~acc_store &  acc_mis;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q   <= in_idx;
            wdata_q <= bus.writeData;
            store_q <= bus.memWrite;
            mis_q   <= in_mis;
            if (in_mis || (bus.memRead && bus.memWrite)) begin
              error_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (bus.readData)
  );

  assign bus.stall = ~reset & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign bus.done  = done_q;
  assign bus.error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: cycle table on a LATENCY=2 responder plus reset-abort and LATENCY=1 sequences.
module tb_dmem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        st;
    logic        dn;
    logic        er;
    logic        chk;
    logic [31:0] rdv;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  dmem_responder_if bus2();
  dmem_responder_if bus1();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic st, input logic dn,
                              input logic er, input logic c, input logic [31:0] rdv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.st = st; v.dn = dn; v.er = er; v.chk = c; v.rdv = rdv;
    return v;
  endfunction

  initial begin
    logic [5:0] stall_pat;
    logic [5:0] done_pat;
    int         seen;
    int         lat;

    n_tests = 0;
    n_fail  = 0;

    // rd, wr, addr, wdata | stall, done, error, check readData, readData
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 0, 1, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10,  32'h0,        1, 0, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10,  32'h0,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h10,  32'h0,        0, 1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 32'h400, 32'h1234,     1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h400, 32'h1234,     1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h400, 32'h1234,     0, 1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 32'h0,   32'h0,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,   32'h0,        0, 1, 0, 1, 32'h1234));
    vecs.push_back(mk(1, 0, 32'h13,  32'h0,        1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h13,  32'h0,        1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h13,  32'h0,        0, 1, 1, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 0, 1, 1, 32'h0));
    vecs.push_back(mk(1, 1, 32'h20,  32'hA5A5A5A5, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h20,  32'hA5A5A5A5, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h20,  32'hA5A5A5A5, 0, 1, 1, 1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h20,  32'h0,        1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h20,  32'h0,        1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h20,  32'h0,        0, 1, 1, 1, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 1, 32'h8,   32'h55,       1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h8,   32'h55,       1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h8,   32'h55,       0, 1, 1, 1, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 32'h0,   32'h0,        0, 0, 1, 1, 32'hA5A5A5A5));

    rst = 1'b1;
    bus2.memRead = 1'b1; bus2.memWrite = 1'b0; bus2.address = '0; bus2.writeData = '0;
    bus1.memRead = 1'b0; bus1.memWrite = 1'b0; bus1.address = '0; bus1.writeData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall_forced", 32'(bus2.stall), 32'h0);
    chk("rst_done",         32'(bus2.done),  32'h0);
    chk("rst_error",        32'(bus2.error), 32'h0);
    chk("rst_rdata",        bus2.readData,   32'h0);
    chk("rst_done_l1",      32'(bus1.done),  32'h0);
    bus2.memRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus2.memRead   = vecs[i].rd;
      bus2.memWrite  = vecs[i].wr;
      bus2.address   = vecs[i].addr;
      bus2.writeData = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus2.stall), 32'(vecs[i].st));
      chk($sformatf("v%0d_done",  i), 32'(bus2.done),  32'(vecs[i].dn));
      chk($sformatf("v%0d_error", i), 32'(bus2.error), 32'(vecs[i].er));
      if (vecs[i].chk) chk($sformatf("v%0d_rdata", i), bus2.readData, vecs[i].rdv);
    end

    // Reset during WAIT aborts the store to word 0x8 (holds 0x55).
    @(negedge clk);
    bus2.memRead = 1'b0; bus2.memWrite = 1'b1; bus2.address = 32'h8; bus2.writeData = 32'hFFFFFFFF;
    #1 chk("abort_accept_stall", 32'(bus2.stall), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_stall", 32'(bus2.stall), 32'h0);
    chk("abort_done",  32'(bus2.done),  32'h0);
    chk("abort_error", 32'(bus2.error), 32'h0);
    chk("abort_rdata", bus2.readData,   32'h0);
    @(negedge clk);
    bus2.memWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (bus2.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);

    @(negedge clk);
    bus2.memRead = 1'b1; bus2.address = 32'h8;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus2.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("abort_lw_latency", 32'(lat), 32'h2);
    chk("abort_lw_rdata",   bus2.readData, 32'h55);
    @(negedge clk);
    bus2.memRead = 1'b0;

    // LATENCY=1: one store, then a load held high for three back-to-back accesses.
    @(negedge clk);
    bus1.memWrite = 1'b1; bus1.address = 32'h4; bus1.writeData = 32'hCAFEF00D;
    #1;
    chk("l1_sw_stall", 32'(bus1.stall), 32'h1);
    chk("l1_sw_done",  32'(bus1.done),  32'h0);
    @(negedge clk);
    bus1.memWrite = 1'b0;
    #1;
    chk("l1_sw_done2",  32'(bus1.done),  32'h1);
    chk("l1_sw_stall2", 32'(bus1.stall), 32'h0);
    stall_pat = 6'b010101;
    done_pat  = 6'b101010;
    @(negedge clk);
    bus1.memRead = 1'b1; bus1.address = 32'h4;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("l1_stall%0d", k), 32'(bus1.stall), 32'(stall_pat[k]));
      chk($sformatf("l1_done%0d",  k), 32'(bus1.done),  32'(done_pat[k]));
      if (done_pat[k]) chk($sformatf("l1_rdata%0d", k), bus1.readData, 32'hCAFEF00D);
    end
    chk("l1_error", 32'(bus1.error), 32'h0);
    @(negedge clk);
    bus1.memRead = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
